// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, FSM
// state encoding, the default data-memory size and the access-error rule.
package lsu_pkg;

    localparam int unsigned LSU_MEM_BYTES = 256;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    // An access errors when its size is reserved, it is not naturally
    // aligned, or its byte address lies beyond the data memory.
    function automatic logic lsu_access_err(input logic [1:0]  size,
                                            input logic [31:0] addr,
                                            input int unsigned mem_bytes);
        logic err;
        err = 1'b0;
        if (size == SZ_RSVD)                       err = 1'b1;
        if (size == SZ_HALF && addr[0])            err = 1'b1;
        if (size == SZ_WORD && addr[1:0] != 2'b00) err = 1'b1;
        if (addr >= 32'(mem_bytes))                err = 1'b1;
        return err;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Bus bundle between the pipeline, the load/store unit and data memory.
//   req_*  : pipeline request (valid/ready handshake)
//   resp_* : one-cycle completion pulse with load data and error flag
//   busy   : stall request back to the pipeline
//   mem_*  : word-wide data-memory port with combinational read data
// Modport slave is the load/store unit side, master the environment side.
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic        mem_wr;
    logic        mem_rd;
    logic [31:0] mem_rd_data;

    modport slave (
        input  req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata, mem_rd_data,
        output req_ready, resp_valid, resp_rdata, resp_err, busy,
               mem_addr, mem_wr_data, mem_wr, mem_rd
    );

    modport master (
        output req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata, mem_rd_data,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy,
               mem_addr, mem_wr_data, mem_wr, mem_rd
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational big-endian lane logic for the load/store unit.
//   word_i     : word read from memory (captured)
//   offset_i   : byte offset within the word
//   size_i     : access size
//   unsigned_i : zero-extend instead of sign-extend on loads
//   wdata_i    : right-justified store data
//   ld_data_o  : extracted and extended load value
//   st_data_o  : word to write back (merged lanes for sub-word stores)
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] st_data_o
);
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Offset 0 is the most significant byte.
    always_comb begin
        ld_byte = 8'h00;
        case (offset_i)
            2'd0:    ld_byte = word_i[31:24];
            2'd1:    ld_byte = word_i[23:16];
            2'd2:    ld_byte = word_i[15:8];
            default: ld_byte = word_i[7:0];
        endcase
        ld_half = offset_i[1] ? word_i[15:0] : word_i[31:16];
    end

    always_comb begin
        ld_data_o = word_i;
        case (size_i)
            SZ_BYTE: ld_data_o = {{24{~unsigned_i & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data_o = {{16{~unsigned_i & ld_half[15]}}, ld_half};
            default: ld_data_o = word_i;
        endcase
    end

    // Each byte lane either keeps the captured byte or takes the matching
    // byte of the store data; a word store takes every lane from wdata.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic       lane_hit;
            logic [7:0] lane_src;
            always_comb begin
                lane_hit = 1'b0;
                lane_src = 8'h00;
                case (size_i)
                    SZ_BYTE: begin
                        lane_hit = (offset_i == 2'(gi));
                        lane_src = wdata_i[7:0];
                    end
                    SZ_HALF: begin
                        lane_hit = (offset_i[1] == 1'(gi / 2));
                        lane_src = (gi % 2 == 0) ? wdata_i[15:8] : wdata_i[7:0];
                    end
                    default: begin
                        lane_hit = 1'b1;
                        lane_src = wdata_i[31-8*gi -: 8];
                    end
                endcase
            end
            assign st_data_o[31-8*gi -: 8] = lane_hit ? lane_src : word_i[31-8*gi -: 8];
        end
    endgenerate

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one pipeline access at a time, performs a
// word-wide read and/or write on data memory, and returns a one-cycle
// response. Sub-word stores use read-modify-write.
//   clk, rst : clock, synchronous active-high reset
//   bus      : request/response/stall and memory port bundle (lsu_if.slave)
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = LSU_MEM_BYTES
) (
    input  logic  clk,
    input  logic  rst,
    lsu_if.slave  bus
);
    lsu_state_e  state_q, state_d;
    logic        wr_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] word_q;

    logic        ready;
    logic        accept;
    logic        req_err;
    logic [31:0] ld_data;
    logic [31:0] st_data;

    assign ready   = (state_q == IDLE);
    assign accept  = bus.req_valid & ready;
    assign req_err = lsu_access_err(bus.req_size, bus.req_addr, MEM_BYTES);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                wr_q    <= bus.req_wr;
                size_q  <= bus.req_size;
                uns_q   <= bus.req_unsigned;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                err_q   <= req_err;
            end
            if (state_q == RD) begin
                word_q <= bus.mem_rd_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_d = RESP;
                    else if (!bus.req_wr || bus.req_size != SZ_WORD)
                        state_d = RD;   // loads and read-modify-write stores
                    else
                        state_d = WR;
                end
            end
            RD:      state_d = wr_q ? WR : RESP;
            WR:      state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    lsu_align u_align (
        .word_i     (word_q),
        .offset_i   (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .wdata_i    (wdata_q),
        .ld_data_o  (ld_data),
        .st_data_o  (st_data)
    );

    assign bus.req_ready   = ready;
    assign bus.busy        = ~ready | bus.req_valid;
    assign bus.mem_addr    = {addr_q[31:2], 2'b00};
    assign bus.mem_wr_data = st_data;
    assign bus.mem_rd      = (state_q == RD);
    assign bus.mem_wr      = (state_q == WR);
    assign bus.resp_valid  = (state_q == RESP);
    assign bus.resp_err    = (state_q == RESP) & err_q;
    assign bus.resp_rdata  = ((state_q == RESP) && !wr_q && !err_q) ? ld_data : 32'h0;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: MEM_BYTES, 256, data-memory size in bytes; addresses >= MEM_BYTES are out of range.
REQ-002 SHALL have a single clock; reset is synchronous and active-high.
REQ-003 SHALL have ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  pipeline access request
- req_ready  out  1  unit can accept a request
- req_wr  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- req_unsigned  in  1  zero-extend loads (lbu/lhu)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  access complete, one-cycle pulse
- resp_rdata  out  32  extended load data
- resp_err  out  1  misaligned, out-of-range or reserved-size access
- busy  out  1  pipeline stall request
- mem_addr  out  32  word-aligned address to data memory
- mem_wr_data  out  32  word written to data memory
- mem_wr  out  1  memory write strobe
- mem_rd  out  1  memory read strobe
- mem_rd_data  in  32  combinational read data from memory

Function
REQ-004 SHALL accept a request on a rising edge when req_valid=1 and req_ready=1, registering wr/size/unsigned/addr/wdata.
REQ-005 SHALL drive req_ready=1 only in IDLE; busy = ~req_ready | req_valid.
REQ-006 SHALL implement states IDLE, RD, WR, RESP, with transitions:
- IDLE->RESP on accept of an erroring request
- IDLE->RD on accept of a load or sub-word store
- IDLE->WR on accept of a word store
- RD->RESP for loads; RD->WR for sub-word stores
- WR->RESP
- RESP->IDLE
REQ-007 SHALL flag an error for a halfword with addr[0]=1, a word with addr[1:0]!=0, size=11, or addr>=MEM_BYTES; an erroring request SHALL assert neither mem_rd nor mem_wr.
REQ-008 SHALL drive mem_addr = {addr[31:2],2'b00} from the registered address.
REQ-009 SHALL assert mem_rd only in RD and mem_wr only in WR, never both in the same cycle.
REQ-010 SHALL capture mem_rd_data into an internal word register at the end of the RD cycle.
REQ-011 SHALL use big-endian byte order: offset 0 = bits 31:24, offset 3 = bits 7:0; halfword offset 0 = bits 31:16.
REQ-012 SHALL sign-extend the selected byte/halfword on loads unless req_unsigned=1, which zero-extends; word loads pass through unchanged.
REQ-013 SHALL form sub-word store data by replacing only the addressed lane(s) of the captured word with req_wdata[7:0] or req_wdata[15:0]; a word store writes req_wdata directly.
REQ-014 SHALL assert resp_valid for exactly one cycle (state RESP), with resp_rdata=0 for stores and errors, and resp_err valid in the same cycle.
REQ-015 SHALL have these latencies from the accept edge to resp_valid: word store 2 cycles; load 2 cycles; sub-word store 3 cycles; error 1 cycle.
REQ-016 SHALL ignore req_valid while not in IDLE; in RESP, a new request is not accepted until the following IDLE cycle.

Reset
REQ-017 SHALL, on rst=1 at a rising edge, enter IDLE and zero resp_valid, resp_rdata, resp_err, mem_wr, mem_rd, mem_addr, mem_wr_data and all request registers.
REQ-018 SHALL abort any in-flight access on reset without a response.
REQ-019 A write already strobed in the WR cycle before the reset edge MAY remain in memory; no further write SHALL occur.
REQ-020 SHALL give rst priority over req_valid in the same cycle.

Structure
REQ-021 SHALL place the size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), the state encoding and the default MEM_BYTES in a shared package lsu_pkg.
REQ-022 SHALL implement lane extraction/extension and store merging in one combinational sub-module lsu_align; the FSM and registers stay in load_store_unit.

Verification
REQ-023 Memory word 0x10 = 0x8899AABB; lb at 0x11 -> rd_data 0xFFFFFF99; lbu at 0x11 -> 0x00000099; resp_err=0; each response 2 cycles after accept.
REQ-024 sh 0x00001234 at 0x12 over word 0x8899AABB -> one mem_rd cycle then one mem_wr cycle with mem_addr=0x10 and mem_wr_data=0x88991234; resp 3 cycles after accept.
REQ-025 sw 0xDEADBEEF at 0x20 -> no mem_rd, one mem_wr with mem_addr=0x20; a following lw at 0x20 returns 0xDEADBEEF.
REQ-026 lw at 0x22, lh at 0x13, size=11, and lw at 0x100 (MEM_BYTES=256) -> each gives resp_err=1 one cycle after accept, rd_data=0, no mem strobes.
REQ-027 rst=1 during the RD cycle of a sub-word store -> no mem_wr, no resp_valid, req_ready=1 the cycle after reset deasserts, target word unchanged.
REQ-028 req_valid held high continuously with back-to-back loads -> no request dropped or duplicated; req_ready low from accept until return to IDLE.
